// File: rtl/sun_score_ssd_driver.sv
// Purpose: 16-bit count -> clamped BCD (double-dabble) -> multiplexed 4-digit SSD; LEADING_ZERO_BLANK_EN blanks leading zeros.
// Latency: 18-cycle conversion pass; digit regs update 17 cycles after the IDLE sample, pins one cycle later.
// Backpressure: none; free-running loop, input changes outside IDLE wait for the next pass.
module sun_score_ssd_driver #(
    parameter int          SCAN_DIV_BITS = 18,
    parameter logic [15:0] MAX_DISPLAY   = 16'd9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] displayNumber,
    output logic [3:0]  anode,
    output logic [6:0]  ssdOut,
    output logic        digitsValid
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                   state, stateNxt;
    logic [15:0]              shReg, shRegNxt;
    logic [15:0]              bcd, bcdNxt, bcdAdj;
    logic [3:0]               shiftCnt, shiftCntNxt;
    logic [15:0]              digits;
    logic                     loadDigits;
    logic [SCAN_DIV_BITS-1:0] scanCnt;
    logic [1:0]               sel;
    logic [3:0]               curDigit;
    logic [3:0]               anodeNxt;
    logic [6:0]               segNxt;

    function automatic logic [6:0] segEncode(input logic [3:0] n);
        case (n)
            4'd0:    segEncode = 7'b0000001;
            4'd1:    segEncode = 7'b1001111;
            4'd2:    segEncode = 7'b0010010;
            4'd3:    segEncode = 7'b0000110;
            4'd4:    segEncode = 7'b1001100;
            4'd5:    segEncode = 7'b0100100;
            4'd6:    segEncode = 7'b0100000;
            4'd7:    segEncode = 7'b0001111;
            4'd8:    segEncode = 7'b0000000;
            4'd9:    segEncode = 7'b0000100;
            default: segEncode = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        stateNxt    = state;
        shRegNxt    = shReg;
        bcdNxt      = bcd;
        shiftCntNxt = shiftCnt;
        loadDigits  = 1'b0;
        bcdAdj      = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcdAdj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        case (state)
            IDLE: begin
                shRegNxt    = (displayNumber > MAX_DISPLAY) ? MAX_DISPLAY : displayNumber;
                bcdNxt      = 16'd0;
                shiftCntNxt = 4'd0;
                stateNxt    = SHIFT;
            end
            SHIFT: begin
                {bcdNxt, shRegNxt} = {bcdAdj, shReg} << 1;
                shiftCntNxt        = shiftCnt + 4'd1;
                if (shiftCnt == 4'd15)
                    stateNxt = DONE;
            end
            DONE: begin
                loadDigits = 1'b1;
                stateNxt   = IDLE;
            end
            default: stateNxt = IDLE;
        endcase
    end

    assign sel      = scanCnt[SCAN_DIV_BITS-1 -: 2];
    assign curDigit = digits[{sel, 2'b00} +: 4];

    always_comb begin
        anodeNxt = ~(4'b0001 << sel);
        segNxt   = segEncode(curDigit);
`ifdef LEADING_ZERO_BLANK_EN
        // d0 is never blanked so a zero count still shows one "0"
        if ((sel == 2'd3 && digits[15:12] == 4'd0) ||
            (sel == 2'd2 && digits[15:8]  == 8'd0) ||
            (sel == 2'd1 && digits[15:4]  == 12'd0)) begin
            anodeNxt = 4'b1111;
            segNxt   = 7'b1111111;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shReg       <= 16'd0;
            bcd         <= 16'd0;
            shiftCnt    <= 4'd0;
            digits      <= 16'd0;
            digitsValid <= 1'b0;
            scanCnt     <= '0;
            anode       <= 4'b1111;
            ssdOut      <= 7'b1111111;
        end else begin
            state       <= stateNxt;
            shReg       <= shRegNxt;
            bcd         <= bcdNxt;
            shiftCnt    <= shiftCntNxt;
            if (loadDigits)
                digits <= bcd;
            digitsValid <= loadDigits;
            scanCnt     <= scanCnt + 1'b1;
            anode       <= anodeNxt;
            ssdOut      <= segNxt;
        end
    end

endmodule

// File: tb/tb_sun_score_ssd_driver.sv
// Bench for sun_score_ssd_driver with a 4-bit scan counter so a full digit scan takes 16 cycles.
// Stimulus pushes the expected decimal per pass; the monitor pops on digitsValid and checks the scanned display.
module tb_sun_score_ssd_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] displayNumber = 16'd0;
    logic [3:0]  anode;
    logic [6:0]  ssdOut;
    logic        digitsValid;

    int          checks = 0;
    int          errors = 0;
    int          rstEpoch = 0;
    bit          monOn = 1'b1;
    int          expQ[$];

    sun_score_ssd_driver #(.SCAN_DIV_BITS(4), .MAX_DISPLAY(16'd9999)) dut (
        .clk           (clk),
        .reset         (reset),
        .displayNumber (displayNumber),
        .anode         (anode),
        .ssdOut        (ssdOut),
        .digitsValid   (digitsValid)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] segRef(input int n);
        logic [6:0] t[10];
        t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        return t[n];
    endfunction

    // Expected segments packed as {d3,d2,d1,d0}, blank = 1111111
    function automatic logic [27:0] expSegs(input int v);
        int d[4];
        logic [27:0] r;
        d[0] = v % 10;
        d[1] = (v / 10) % 10;
        d[2] = (v / 100) % 10;
        d[3] = (v / 1000) % 10;
        for (int i = 0; i < 4; i++) r[7*i +: 7] = segRef(d[i]);
`ifdef LEADING_ZERO_BLANK_EN
        if (v < 1000) r[27:21] = 7'h7F;
        if (v < 100)  r[20:14] = 7'h7F;
        if (v < 10)   r[13:7]  = 7'h7F;
`endif
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic waitValid(output int n);
        n = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (digitsValid) begin
                n = c;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL valid_timeout: got no digitsValid expected one within 60 cycles");
    endtask

    task automatic issue(input logic [15:0] v, input int expVal);
        displayNumber = v;
        expQ.push_back(expVal);
    endtask

    // Monitor: each digitsValid pops one expectation and scans the next 16 cycles of pins
    initial begin
        int          e;
        int          ep;
        logic [27:0] got;
        bit          bad;
        forever begin
            @(negedge clk);
            if (digitsValid && monOn) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got digitsValid expected none (queue empty)");
                end else begin
                    e   = expQ.pop_front();
                    ep  = rstEpoch;
                    got = {4{7'h7F}};
                    bad = 1'b0;
                    for (int c = 0; c < 16; c++) begin
                        @(negedge clk);
                        case (anode)
                            4'b1110: got[6:0]   = ssdOut;
                            4'b1101: got[13:7]  = ssdOut;
                            4'b1011: got[20:14] = ssdOut;
                            4'b0111: got[27:21] = ssdOut;
                            4'b1111: ;
                            default: bad = 1'b1;
                        endcase
                    end
                    if (ep == rstEpoch) begin
                        checks++;
                        if (bad || got !== expSegs(e)) begin
                            errors++;
                            $display("FAIL display_%0d: got segs %h (bad anode %0b) expected %h",
                                     e, got, bad, expSegs(e));
                        end
                    end
                end
            end
        end
    end

    initial begin
        int  n;
        bit  zeroOk;
        bit  litSeen;

        issue(16'd1234, 1234);
        repeat (3) @(negedge clk);
        check("rst_anode", {28'd0, anode}, 32'hF);
        check("rst_ssd", {25'd0, ssdOut}, 32'h7F);
        check("rst_valid", {31'd0, digitsValid}, 32'd0);
        reset = 1'b0;
        check("rel_anode", {28'd0, anode}, 32'hF);
        waitValid(n);
        check("first_valid_cycle", n, 18);

        issue(16'd65535, 9999);
        waitValid(n);
        issue(16'd10000, 9999);
        waitValid(n);
        issue(16'd9999, 9999);
        waitValid(n);
        issue(16'd0, 0);
        waitValid(n);
        issue(16'd7, 7);
        waitValid(n);
        issue(16'd42, 42);
        waitValid(n);
        issue(16'd8765, 8765);
        waitValid(n);
        check("pass_period", n, 18);

        // Mid-pass input change must not tear the result
        issue(16'd5, 5);
        repeat (3) @(negedge clk);
        displayNumber = 16'd6;
        waitValid(n);
        issue(16'd6, 6);
        waitValid(n);
        issue(16'd300, 300);
        waitValid(n);

        // One-cycle reset in the middle of a SHIFT pass
        displayNumber = 16'd4321;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        rstEpoch++;
        expQ.push_back(4321);
        @(negedge clk);
        check("midrst_anode", {28'd0, anode}, 32'hF);
        check("midrst_ssd", {25'd0, ssdOut}, 32'h7F);
        check("midrst_valid", {31'd0, digitsValid}, 32'd0);
        reset = 1'b0;
        zeroOk  = 1'b1;
        litSeen = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (anode != 4'b1111) begin
                litSeen = 1'b1;
                if (ssdOut != 7'b0000001) zeroOk = 1'b0;
            end
        end
        check("midrst_zero_digits", {30'd0, litSeen, zeroOk}, 32'd3);
        waitValid(n);
        check("midrst_valid_cycle", n, 2);

        repeat (17) @(negedge clk);
        monOn = 1'b0;
        check("queue_drained", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
